alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the combinational datapath ALU. It adds the XOR, SLT and MUL operations, a registered result with a full flag set, and a valid/ready interface on both sides. Single-cycle operations complete in one cycle. MUL runs on an iterative shift-add engine. The block sits between operand fetch and writeback and stalls upstream while it is busy or backpressured.

## Interface
- `WIDTH`, default 32: operand and result width in bits. Must be at least 2.
- `clk`  in  1: sole clock. All state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `valid_i`  in  1: operands and op presented.
- `ready_o`  out  1: block accepts this cycle. A transfer occurs when `valid_i` and `ready_o` are both high.
- `rs_i`  in  WIDTH: operand A.
- `rt_i`  in  WIDTH: operand B.
- `op_i`  in  3: operation code.
  - 000 OR
  - 001 AND
  - 010 ADD
  - 011 SUB
  - 100 XOR
  - 101 SLT
  - 110 MUL
  - 111 reserved
- `valid_o`  out  1: result registers hold a valid result.
- `ready_i`  in  1: downstream consumes the result. A transfer occurs when `valid_o` and `ready_i` are both high.
- `result_o`  out  WIDTH: registered result.
- `zero_o`  out  1: high when `result_o` is 0.
- `carry_o`  out  1: carry / high-product flag (see Operation).
- `ovf_o`  out  1: signed overflow flag.

## Operation
- **FSM states:** IDLE, BUSY, HOLD.
  - **IDLE:** `ready_o`=1. On acceptance of a non-MUL op, compute the result and register it, then go to HOLD. On acceptance of MUL, latch the operands, clear the accumulator, load the counter with WIDTH, and go to BUSY.
  - **BUSY:** `ready_o`=0. Each cycle, if multiplier bit 0 is 1, add the multiplicand into the accumulator. Then shift the multiplicand left and the multiplier right, and decrement the counter. When the counter reaches 0, register the result and go to HOLD.
  - **HOLD:** `valid_o`=1.
    - `ready_i`=0: stay in HOLD. All outputs are held bit-stable.
    - `ready_i`=1 with no new acceptance: go to IDLE.
    - In HOLD, `ready_o` = `ready_i`. This is a combinational path, and it is intended. Acceptance and drain in the same cycle behave as an IDLE acceptance, which gives back-to-back throughput of one single-cycle op per cycle.
- **Operand capture:** operands and op are captured only at acceptance. Input changes after acceptance have no effect.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH.
  - **ADD:** `carry_o` = carry out of bit WIDTH-1. `ovf_o` = the two operands have the same sign and the result sign differs.
  - **SUB:** computed as `rs_i` + ~`rt_i` + 1. `carry_o` = carry out, so 1 means no borrow. `ovf_o` = the operands have differing signs and the result sign differs from `rs_i`.
  - **SLT:** result is 1 if `rs_i` < `rt_i` as signed values, else 0.
  - **MUL:** unsigned. `result_o` = low WIDTH bits of the product. `carry_o` = 1 if any of the high WIDTH product bits is nonzero.
  - **Flags for other ops:** OR, AND, XOR, SLT and reserved ops produce `carry_o`=0 and `ovf_o`=0.
  - **Reserved (111):** result 0 and `zero_o`=1, with 1-cycle latency.
- **Flag timing:** `zero_o`, `carry_o` and `ovf_o` are registered together with `result_o`.

## Timing
- **Reset:** a reset edge forces state IDLE. `valid_o`, `result_o`, `zero_o`, `carry_o`, `ovf_o`, the accumulator and the counter are all reset to 0. `ready_o` is 1 in the first cycle after reset.
- **Reset mid-operation:** reset has priority over everything. An in-flight MUL or an undrained HOLD result is discarded with no output.
- **Latency, non-MUL:** acceptance at edge N gives `valid_o`=1 after edge N+1.
- **Latency, MUL:** `valid_o`=1 after edge N+WIDTH+1. `ready_o`=0 for WIDTH cycles.
- **Simultaneous events:** in HOLD with `ready_i`=1 and `valid_i`=1, the old result drains and the new op is accepted on the same edge. For a single-cycle op, `valid_o` stays 1 and the new values appear.

## Configuration
- **`ALU_SEQ_MUL_EN` defined:** MUL is implemented as described, using the BUSY state, accumulator and counter.
- **`ALU_SEQ_MUL_EN` undefined:** no multiply hardware is built. BUSY is unreachable. Op 110 behaves as reserved: result 0, `zero_o`=1, 1-cycle latency.

## Test plan
- **ADD overflow:** ADD 0x7FFFFFFF + 0x00000001 with `ready_i`=1 -> one cycle later `result_o`=0x80000000, `ovf_o`=1, `carry_o`=0, `zero_o`=0.
- **SUB to zero:** SUB 5 - 5 -> `result_o`=0, `zero_o`=1, `carry_o`=1, `ovf_o`=0. Then SLT 0xFFFFFFFF vs 1 -> `result_o`=1.
- **MUL with high product:** MUL 0x00010000 × 0x00010000 -> `ready_o`=0 for 32 cycles, then `valid_o`=1 with `result_o`=0, `zero_o`=1, `carry_o`=1. MUL 7 × 6 -> 42, `carry_o`=0.
- **Backpressure:** XOR 0xF0F0 ^ 0x0FF0, hold `ready_i`=0 for 3 cycles -> `result_o`=0xFF00 stable and `ready_o`=0 throughout. Then raise `ready_i` with a new ADD present -> accepted the same cycle, and the next cycle `valid_o`=1 with the ADD result.
- **Reset mid-multiply:** reset pulsed 10 cycles into a MUL -> next cycle `valid_o`=0, `ready_o`=1, all outputs 0. The aborted result is never presented.
- **Macro off:** with `ALU_SEQ_MUL_EN` undefined, MUL 3 × 3 -> 1-cycle latency, `result_o`=0, `zero_o`=1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [2:0]       op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam logic [2:0] OP_OR  = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam int CW = $clog2(WIDTH + 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  state_t state;

  logic accept;

  assign ready_o = (state == IDLE) ||
                   ((state == HOLD) && ready_i);
  assign accept  = valid_i && ready_o;

  logic             sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    sub     = (op_i == OP_SUB);
    b_op    = sub ? ~rt_i : rt_i;
    sum     = {1'b0, rs_i} + {1'b0, b_op} +
              {{WIDTH{1'b0}}, sub};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op_i)
      OP_OR:  alu_res = rs_i | rt_i;
      OP_AND: alu_res = rs_i & rt_i;
      OP_XOR: alu_res = rs_i ^ rt_i;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (rs_i[WIDTH-1] == rt_i[WIDTH-1]) &&
                  (sum[WIDTH-1] != rs_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (rs_i[WIDTH-1] != rt_i[WIDTH-1]) &&
                  (sum[WIDTH-1] != rs_i[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                         $signed(rs_i) < $signed(rt_i)};
      // MUL is handled by the sequencer; 110/111 fall to zero here
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign acc_nx = acc + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid_o  <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b0;
      carry_o  <= 1'b0;
      ovf_o    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (op_i == OP_MUL) begin
              mcand   <= {{WIDTH{1'b0}}, rs_i};
              mplier  <= rt_i;
              acc     <= '0;
              cnt     <= CW'(WIDTH);
              valid_o <= 1'b0;
              state   <= BUSY;
            end else
`endif
            begin
              result_o <= alu_res;
              zero_o   <= (alu_res == '0);
              carry_o  <= alu_c;
              ovf_o    <= alu_v;
              valid_o  <= 1'b1;
              state    <= HOLD;
            end
          end else if (state == HOLD && ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
        BUSY: begin
`ifdef ALU_SEQ_MUL_EN
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result_o <= acc_nx[WIDTH-1:0];
            zero_o   <= (acc_nx[WIDTH-1:0] == '0);
            carry_o  <= |acc_nx[2*WIDTH-1:WIDTH];
            ovf_o    <= 1'b0;
            valid_o  <= 1'b1;
            state    <= HOLD;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: vector table, hand sequences, random vs model.
// Honours ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic [2:0]  op_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        carry_o;
  logic        ovf_o;

  int checks = 0;
  int errors = 0;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  alu_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .rs_i     (rs_i),
    .rt_i     (rt_i),
    .op_i     (op_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .carry_o  (carry_o),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  function automatic exp_t model(logic [2:0] op,
                                 logic [31:0] a,
                                 logic [31:0] b);
    exp_t e;
    longint          sa, sb, s;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.r = 32'd0; e.c = 1'b0; e.v = 1'b0; e.lat = 0;
    case (op)
      3'd0: e.r = a | b;
      3'd1: e.r = a & b;
      3'd2: begin
        e.r = a + b;
        e.c = ((ua + ub) >> 32) != 0;
        s   = sa + sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd3: begin
        e.r = a - b;
        e.c = (ua >= ub);
        s   = sa - sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd4: e.r = a ^ b;
      3'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: if (MUL_EN) begin
        p     = ua * ub;
        e.r   = p[31:0];
        e.c   = p[63:32] != 0;
        e.lat = 32;
      end
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Presents one op, waits for acceptance, then counts edges to valid_o.
  task automatic send(input logic [2:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      output int lat);
    int n;
    valid_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", ready_o, 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    op_i = 3'($urandom);
    rs_i = $urandom;
    rt_i = $urandom;
    n = 0;
    while (!valid_o && n < 100) begin
      chk("busy_ready_low", ready_o, 0);
      @(posedge clk); #1; n++;
    end
    lat = n;
  endtask

  task automatic check_out(input string nm, input exp_t e, input int lat);
    chk({nm, "_valid"}, valid_o, 1);
    chk({nm, "_lat"}, lat, e.lat);
    chk({nm, "_res"}, result_o, e.r);
    chk({nm, "_flags"}, {zero_o, carry_o, ovf_o}, {e.z, e.c, e.v});
  endtask

  task automatic drain();
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("drain_valid", valid_o, 0);
    ready_i = 1'b0;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] a, b, r,
                      input logic z, c, v, input int lat);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.r = r;
    t.z = z; t.c = c; t.v = v; t.lat = lat;
    tbl.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    exp_t e;
    logic [31:0] a, b, hold_r;
    logic [2:0]  op;
    logic [31:0] edge_v[4];
    exp_t        bb[4];

    push(3'd2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 1, 0);
    push(3'd3, 32'd5, 32'd5, 32'd0, 1, 1, 0, 0);
    push(3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 0);
    push(3'd4, 32'hF0F0, 32'h0FF0, 32'hFF00, 0, 0, 0, 0);
    push(3'd0, 32'h0F00, 32'h00F0, 32'h0FF0, 0, 0, 0, 0);
    push(3'd1, 32'hFF00, 32'h0FF0, 32'h0F00, 0, 0, 0, 0);
    push(3'd3, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    push(3'd3, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 1, 0);
    push(3'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1, 0, 0);
    push(3'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1, 0, 0, 0);
    push(3'd7, 32'h1234, 32'h5678, 32'd0, 1, 0, 0, 0);
`ifdef ALU_SEQ_MUL_EN
    push(3'd6, 32'h0001_0000, 32'h0001_0000, 32'd0, 1, 1, 0, 32);
    push(3'd6, 32'd7, 32'd6, 32'd42, 0, 0, 0, 32);
`else
    push(3'd6, 32'd3, 32'd3, 32'd0, 1, 0, 0, 0);
`endif

    reset = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    rs_i = '0; rt_i = '0; op_i = '0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_out", {result_o, zero_o, carry_o, ovf_o}, 0);

    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      e.r = tbl[i].r; e.z = tbl[i].z; e.c = tbl[i].c;
      e.v = tbl[i].v; e.lat = tbl[i].lat;
      check_out($sformatf("vec%0d", i), e, lat);
      drain();
    end

    // Backpressure, then drain and accept on the same edge
    send(3'd4, 32'hF0F0, 32'h0FF0, lat);
    repeat (3) begin
      chk("bp_res", result_o, 32'hFF00);
      chk("bp_valid", valid_o, 1);
      chk("bp_ready", ready_o, 0);
      @(posedge clk); #1;
    end
    valid_i = 1'b1; op_i = 3'd2; rs_i = 32'd3; rt_i = 32'd4;
    ready_i = 1'b1;
    #1;
    chk("bp_pass_ready", ready_o, 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("bp_new_valid", valid_o, 1);
    chk("bp_new_res", result_o, 32'd7);
    @(posedge clk); #1;
    chk("bp_drained", valid_o, 0);
    ready_i = 1'b0;

    // Back-to-back single-cycle stream
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = 3'($urandom_range(0, 5));
      a = $urandom; b = $urandom;
      bb[i] = model(op, a, b);
      valid_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
      #1;
      chk("b2b_ready", ready_o, 1);
      @(posedge clk); #1;
      chk("b2b_valid", valid_o, 1);
      chk("b2b_res", result_o, bb[i].r);
      edge_v[i] = result_o;
    end
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end", valid_o, 0);
    ready_i = 1'b0;

    // Reset discards an undrained HOLD result with nonzero flags
    send(3'd2, 32'hFFFF_FFFF, 32'h8000_0000, lat);
    chk("hrst_pre", {carry_o, ovf_o}, 2'b11);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("hrst_valid", valid_o, 0);
    chk("hrst_ready", ready_o, 1);
    chk("hrst_out", {result_o, zero_o, carry_o, ovf_o}, 0);

`ifdef ALU_SEQ_MUL_EN
    valid_i = 1'b1; op_i = 3'd6; rs_i = 32'd9; rt_i = 32'd9;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mrst_busy", ready_o, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_valid", valid_o, 0);
    chk("mrst_ready", ready_o, 1);
    chk("mrst_out", {result_o, zero_o, carry_o, ovf_o}, 0);
    hold_r = 32'd0;
    repeat (40) begin
      @(posedge clk); #1;
      hold_r = hold_r | {31'd0, valid_o};
    end
    chk("mrst_no_result", hold_r, 0);
`endif

    // Random ops against the reference model, with random backpressure
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (op == 3'd6) b = b & 32'h0001_FFFF;
      e = model(op, a, b);
      send(op, a, b, lat);
      check_out($sformatf("rnd%0d", i), e, lat);
      hold_r = result_o;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("rnd_stable", {valid_o, result_o}, {1'b1, hold_r});
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
